trng_word_collector: RTL and testbench

- Consumer end of the raw-bit sampling path. It reads the single-bit sampled entropy stream from the DFF sampler output, decimates it, and packs accepted bits MSB-first into WORD_W-bit words.
- Finished words are presented on a valid/ready interface to the downstream transmitter (UART TX or FIFO).
- A sticky overrun flag reports any word lost because downstream stalled.

---
 rtl/trng_word_collector.sv | 143 ++++++++++++++
 tb/tb_trng_word_collector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/trng_word_collector.sv
// Decimates the sampled entropy bit stream and packs accepted bits MSB-first into
// WORD_W-bit words on a valid/ready interface. Define TRNG_VON_NEUMANN_EN for pair debiasing.
module trng_word_collector #(
    parameter int WORD_W     = 8,
    parameter int SAMPLE_DIV = 4
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        ce,
    input  logic                        bit_in,
    output logic [WORD_W-1:0]           word_out,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic                        overrun,
    output logic [$clog2(WORD_W+1)-1:0] bit_cnt
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    generate
        if (WORD_W < 2 || WORD_W > 32) begin : g_bad_word_w
            $error("trng_word_collector: WORD_W must be in 2..32");
        end
        if (SAMPLE_DIV < 1 || SAMPLE_DIV > 256) begin : g_bad_sample_div
            $error("trng_word_collector: SAMPLE_DIV must be in 1..256");
        end
    endgenerate

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              strobe;
    logic              acc_valid;
    logic              acc_bit;
    logic [WORD_W-1:0] new_word;
    logic              hold_free;

    assign strobe = ce && (div_cnt_q == DIV_LAST);

`ifdef TRNG_VON_NEUMANN_EN
    logic phase_q, phase_d;
    logic s0_q, s0_d;

    // Only unequal pairs yield a bit, and its value is the first sample of the pair.
    always_comb begin
        phase_d   = phase_q;
        s0_d      = s0_q;
        acc_valid = 1'b0;
        acc_bit   = s0_q;
        if (strobe) begin
            if (!phase_q) begin
                s0_d    = bit_in;
                phase_d = 1'b1;
            end else begin
                phase_d   = 1'b0;
                acc_valid = s0_q ^ bit_in;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            phase_q <= 1'b0;
            s0_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            s0_q    <= s0_d;
        end
    end
`else
    assign acc_valid = strobe;
    assign acc_bit   = bit_in;
`endif

    assign new_word  = {shreg_q[WORD_W-2:0], acc_bit};
    assign hold_free = !valid_q || word_ready;

    // NOTE: every signal driven here gets its default first, so no path can infer a latch.
    always_comb begin
        div_cnt_d = div_cnt_q;
        shreg_d   = shreg_q;
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;

        if (ce) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        end

        if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end

        if (acc_valid) begin
            shreg_d = new_word;
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                // A word completing on a transfer cycle replaces the one leaving.
                if (hold_free) begin
                    word_d  = new_word;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_cnt_q <= '0;
            shreg_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            shreg_q   <= shreg_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign overrun    = overrun_q;
    assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_trng_word_collector.sv
// Directed bench for trng_word_collector (WORD_W=8, SAMPLE_DIV=4); runs the
// Von Neumann scenario instead of the plain ones when TRNG_VON_NEUMANN_EN is defined.
module tb_trng_word_collector;

    localparam int WORD_W     = 8;
    localparam int SAMPLE_DIV = 4;

    logic       clk;
    logic       clr;
    logic       ce;
    logic       bit_in;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready;
    logic       overrun;
    logic [3:0] bit_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    trng_word_collector #(
        .WORD_W    (WORD_W),
        .SAMPLE_DIV(SAMPLE_DIV)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .ce        (ce),
        .bit_in    (bit_in),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .overrun   (overrun),
        .bit_cnt   (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Leaves the bench 1 time unit after the last rising edge.
    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // From a divider-aligned point, presents one bit for exactly one strobe.
    task automatic strobe_bit(input logic b);
        bit_in = b;
        clocks(SAMPLE_DIV);
    endtask

    task automatic send_range(input logic [7:0] w, input int from, input int to);
        for (int i = from; i <= to; i++) strobe_bit(w[7-i]);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        #2;
        clr = 1'b1;
    endtask

    initial begin
        clr        = 1'b0;
        ce         = 1'b1;
        bit_in     = 1'b1;
        word_ready = 1'b0;
        #12;
        check("rst_word_out", word_out, 8'h00);
        check("rst_valid", word_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        clr = 1'b1;

`ifdef TRNG_VON_NEUMANN_EN
        begin
            logic [7:0] pat;
            pat = 8'b1011_0100;  // pairs (1,0),(1,1),(0,1),(0,0)
            for (int i = 0; i < 8; i++) strobe_bit(pat[7-i]);
            check("vn_cnt_after_4pairs", bit_cnt, 2);
            check("vn_valid_early", word_valid, 0);
            for (int r = 1; r < 4; r++)
                for (int i = 0; i < 8; i++) strobe_bit(pat[7-i]);
            check("vn_valid", word_valid, 1);
            check("vn_word", word_out, 8'hAA);
            check("vn_cnt_wrap", bit_cnt, 0);
            check("vn_overrun_first", overrun, 0);
            for (int r = 0; r < 4; r++)
                for (int i = 0; i < 8; i++) strobe_bit(pat[7-i]);
            check("vn_word_held", word_out, 8'hAA);
            check("vn_overrun_second", overrun, 1);
        end
`else
        // Reset release: first strobe on the 4th clock, then bit_cnt walks 1..7, 0.
        clocks(SAMPLE_DIV - 1);
        check("rr_no_strobe_yet", bit_cnt, 0);
        clocks(1);
        check("rr_first_strobe", bit_cnt, 1);
        for (int k = 2; k <= 8; k++) begin
            clocks(SAMPLE_DIV);
            check($sformatf("rr_bit_cnt_%0d", k), bit_cnt, k % 8);
            if (k == 7) check("rr_valid_before", word_valid, 0);
        end
        check("rr_valid", word_valid, 1);
        check("rr_word", word_out, 8'hFF);
        check("rr_overrun", overrun, 0);

        // Pattern with word_ready high: the old FF drains, then A5 appears for one cycle.
        word_ready = 1'b1;
        send_range(8'hA5, 0, 0);
        check("pat_drained", word_valid, 0);
        send_range(8'hA5, 1, 7);
        check("pat_valid", word_valid, 1);
        check("pat_word", word_out, 8'hA5);
        check("pat_overrun", overrun, 0);
        clocks(1);
        check("pat_one_cycle", word_valid, 0);

        // Stall: second completed word is dropped.
        do_reset();
        word_ready = 1'b0;
        send_range(8'h3C, 0, 7);
        check("st_valid1", word_valid, 1);
        check("st_word1", word_out, 8'h3C);
        send_range(8'h0F, 0, 6);
        check("st_overrun_mid", overrun, 0);
        send_range(8'h0F, 7, 7);
        check("st_word_kept", word_out, 8'h3C);
        check("st_valid_kept", word_valid, 1);
        check("st_overrun", overrun, 1);
        check("st_cnt", bit_cnt, 0);
        word_ready = 1'b1;
        clocks(1);
        check("st_transfer", word_valid, 0);
        clocks(2);
        check("st_single_transfer", word_valid, 0);
        check("st_overrun_sticky", overrun, 1);

        // Simultaneous transfer and completion.
        do_reset();
        word_ready = 1'b0;
        send_range(8'h12, 0, 7);
        check("sim_word1", word_out, 8'h12);
        send_range(8'h34, 0, 6);
        bit_in = 1'b0;  // LSB of 8'h34
        clocks(SAMPLE_DIV - 1);
        word_ready = 1'b1;
        clocks(1);
        check("sim_valid", word_valid, 1);
        check("sim_word2", word_out, 8'h34);
        check("sim_overrun", overrun, 0);
        word_ready = 1'b0;

        // ce gap mid-word, then asynchronous reset mid-word.
        do_reset();
        send_range(8'hD5, 0, 2);
        check("ce_cnt3", bit_cnt, 3);
        ce = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit_in = ~bit_in;
            clocks(1);
        end
        check("ce_hold_cnt", bit_cnt, 3);
        check("ce_hold_valid", word_valid, 0);
        ce = 1'b1;
        send_range(8'hD5, 3, 6);
        check("ce_cnt7", bit_cnt, 7);
        check("ce_not_done", word_valid, 0);
        send_range(8'hD5, 7, 7);
        check("ce_valid", word_valid, 1);
        check("ce_word", word_out, 8'hD5);
        send_range(8'hFF, 0, 7);
        check("ce_overrun", overrun, 1);
        send_range(8'hC0, 0, 1);
        check("ce_partial", bit_cnt, 2);
        clr = 1'b0;
        #1;
        check("async_cnt", bit_cnt, 0);
        check("async_valid", word_valid, 0);
        check("async_overrun", overrun, 0);
        check("async_word", word_out, 8'h00);
        clr = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
